// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, read FSM states and bit-reverse helper for the FFT tail
package fft_pkg;

  localparam int DATA_W = 24;
  localparam int N_LOG2 = 9;
  localparam int N      = 1 << N_LOG2;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) begin
      r[i] = a[N_LOG2-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_ram.sv
// rtl/reorder_ram.sv - simple dual-port RAM, one write port and one registered read port
module reorder_ram #(
  parameter int DW = 48,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  // Contents are never reset; the top only forwards read data when it is qualified.
  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong reorder buffer, bit-reversed frames in, natural-order bursts out
module fft_out_reorder #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int N_LOG2 = fft_pkg::N_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] din_r,
  input  logic [DATA_W-1:0] din_i,
  output logic              out_valid,
  output logic [DATA_W-1:0] dout_r,
  output logic [DATA_W-1:0] dout_i,
  output logic [N_LOG2-1:0] out_idx,
  output logic              out_sop,
  output logic              out_eop
);

  import fft_pkg::*;

  localparam logic [N_LOG2-1:0] LAST = '1;

  logic [N_LOG2-1:0] wr_cnt_q;
  logic              wr_sel_q;
  logic [N_LOG2-1:0] wr_rev;
  logic              rd_start;

  rd_state_e         state_q, state_d;
  logic [N_LOG2-1:0] rd_cnt_q, rd_cnt_d;
  logic              rd_sel_q, rd_sel_d;
  logic              rd_en;

  logic              v1_q;
  logic [N_LOG2-1:0] idx1_q;
  logic [2*DATA_W-1:0] rdata;

  for (genvar g = 0; g < N_LOG2; g++) begin : g_rev
    assign wr_rev[g] = wr_cnt_q[N_LOG2-1-g];
  end

  assign rd_start = in_valid && (wr_cnt_q == LAST);

  // Write counter wraps to 0 naturally on the frame-completing sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      wr_sel_q <= 1'b0;
    end else if (in_valid) begin
      wr_cnt_q <= wr_cnt_q + 1'b1;
      if (rd_start) begin
        wr_sel_q <= ~wr_sel_q;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    rd_sel_d = rd_sel_q;
    rd_en    = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (rd_start) begin
          state_d  = RD_READ;
          rd_cnt_d = '0;
          rd_sel_d = wr_sel_q;
        end
      end
      RD_READ: begin
        rd_en    = 1'b1;
        rd_cnt_d = rd_cnt_q + 1'b1;
        // wr_sel_q still names the bank just filled on the edge rd_start is seen.
        if (rd_cnt_q == LAST) begin
          if (rd_start) begin
            rd_sel_d = wr_sel_q;
          end else begin
            state_d = RD_IDLE;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RD_IDLE;
      rd_cnt_q <= '0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  reorder_ram #(
    .DW(2*DATA_W),
    .AW(N_LOG2+1)
  ) u_ram (
    .clk     (clk),
    .we_i    (in_valid),
    .waddr_i ({wr_sel_q, wr_rev}),
    .wdata_i ({din_r, din_i}),
    .re_i    (rd_en),
    .raddr_i ({rd_sel_q, rd_cnt_q}),
    .rdata_o (rdata)
  );

  // Stage 1 tracks the RAM read latency; stage 2 is the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      idx1_q    <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_idx   <= '0;
      dout_r    <= '0;
      dout_i    <= '0;
    end else begin
      v1_q      <= rd_en;
      idx1_q    <= rd_cnt_q;
      out_valid <= v1_q;
      out_sop   <= v1_q && (idx1_q == '0);
      out_eop   <= v1_q && (idx1_q == LAST);
      out_idx   <= v1_q ? idx1_q : '0;
      dout_r    <= v1_q ? rdata[2*DATA_W-1:DATA_W] : '0;
      dout_i    <= v1_q ? rdata[DATA_W-1:0] : '0;
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb/tb_fft_out_reorder.sv - randomized directed bench with a frame-level reorder reference model
module tb_fft_out_reorder;
  import fft_pkg::*;

  localparam int NN = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] din_r, din_i;
  logic        out_valid;
  logic [23:0] dout_r, dout_i;
  logic [8:0]  out_idx;
  logic        out_sop, out_eop;

  fft_out_reorder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .din_r     (din_r),
    .din_i     (din_i),
    .out_valid (out_valid),
    .dout_r    (dout_r),
    .dout_i    (dout_i),
    .out_idx   (out_idx),
    .out_sop   (out_sop),
    .out_eop   (out_eop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [8:0]  idx;
    logic [23:0] r;
    logic [23:0] i;
    logic        sop;
    logic        eop;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        got_q[$];
  logic [23:0] fr_r [NN];
  logic [23:0] fr_i [NN];
  int          k_in;
  int          cyc;
  int          frames_done;
  int          last_in_cyc;
  int          n_cmp;
  int          n_bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // One cycle: sample outputs at the falling edge, then drive this cycle's input.
  // A frame completed at the edge after negedge c shows bin j at negedge c+3+j.
  task automatic step(input logic v, input logic [23:0] r, input logic [23:0] im);
    @(negedge clk);
    cyc++;
    if (out_valid === 1'b1) begin
      got_q.push_back('{cyc, out_idx, dout_r, dout_i, out_sop, out_eop});
    end
    in_valid = v;
    din_r    = r;
    din_i    = im;
    if (v && rst_n) begin
      fr_r[k_in] = r;
      fr_i[k_in] = im;
      k_in++;
      if (k_in == NN) begin
        for (int j = 0; j < NN; j++) begin
          exp_q.push_back('{cyc + 3 + j, 9'(j), fr_r[bitrev(9'(j))], fr_i[bitrev(9'(j))],
                            j == 0, j == NN - 1});
        end
        k_in        = 0;
        last_in_cyc = cyc;
        frames_done++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 24'h0, 24'h0);
  endtask

  task automatic rand_frame();
    for (int k = 0; k < NN; k++) step(1'b1, 24'($urandom), 24'($urandom));
  endtask

  task automatic check_frames(input string tag);
    chk({tag, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int n = 0; n < got_q.size() && n < exp_q.size(); n++) begin
      chk($sformatf("%s time %0d", tag, n), 64'(got_q[n].cyc), 64'(exp_q[n].cyc));
      chk($sformatf("%s idx/sop/eop %0d", tag, n),
          64'({got_q[n].idx, got_q[n].sop, got_q[n].eop}),
          64'({exp_q[n].idx, exp_q[n].sop, exp_q[n].eop}));
      chk($sformatf("%s data %0d", tag, n),
          64'({got_q[n].r, got_q[n].i}), 64'({exp_q[n].r, exp_q[n].i}));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, 64'({out_valid, out_sop, out_eop, out_idx, dout_r, dout_i}), 64'h0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && dut.rd_start === 1'b1 && dut.state_q == RD_READ
        && dut.rd_cnt_q !== 9'h1FF) begin
      n_cmp++;
      n_bad++;
      $error("FAIL rd_start overlap: got rd_cnt %0d want 511", dut.rd_cnt_q);
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; k_in = 0; frames_done = 0; last_in_cyc = 0;
    in_valid = 1'b0; din_r = '0; din_i = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_outputs_zero("reset outputs");
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Single frame, data = arrival index, imag = its negation.
    for (int k = 0; k < NN; k++) step(1'b1, 24'(k), 24'(-k));
    idle(520);
    if (got_q.size() == NN) begin
      chk("bin1 r", 64'(got_q[1].r), 64'd256);
      chk("bin2 r", 64'(got_q[2].r), 64'd128);
      chk("bin3 r", 64'(got_q[3].r), 64'd384);
      chk("bin511 r", 64'(got_q[511].r), 64'd511);
      chk("bin1 i", 64'(got_q[1].i), 64'h00FFFF00);
      chk("bin0 sop", 64'(got_q[0].sop), 64'd1);
      chk("bin511 eop", 64'(got_q[511].eop), 64'd1);
      chk("first latency", 64'(got_q[0].cyc), 64'(last_in_cyc + 3));
    end
    check_frames("single");

    // Three back-to-back frames: one continuous 1536-cycle burst.
    for (int f = 0; f < 3; f++) rand_frame();
    idle(520);
    chk("b2b length", 64'(got_q.size()), 64'(3 * NN));
    check_frames("b2b");

    // Two frames at roughly 30% input duty.
    begin
      int target = frames_done + 2;
      int guard  = 0;
      while (frames_done < target && guard < 20000) begin
        step(($urandom_range(0, 99) < 30), 24'($urandom), 24'($urandom));
        guard++;
      end
      chk("sparse frames complete", 64'(frames_done >= target), 64'd1);
    end
    idle(520);
    check_frames("sparse");

    // Reset after 300 samples of a frame, then a fresh full frame.
    for (int k = 0; k < 300; k++) step(1'b1, 24'($urandom), 24'($urandom));
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    k_in = 0;
    #1 chk_outputs_zero("mid-frame reset outputs");
    idle(3);
    rst_n = 1'b1;
    rand_frame();
    idle(520);
    check_frames("after frame reset");

    // Reset in the middle of an output burst, at bin 200.
    rand_frame();
    begin
      int guard = 0;
      while (got_q.size() < 201 && guard < 600) begin
        idle(1);
        guard++;
      end
    end
    #2 rst_n = 1'b0;
    #1 chk("burst reset valid", 64'(out_valid), 64'd0);
    chk_outputs_zero("burst reset outputs");
    while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
    check_frames("pre-reset burst");
    idle(3);
    rst_n = 1'b1;
    idle(100);
    chk("quiet after burst reset", 64'(got_q.size()), 64'd0);
    rand_frame();
    idle(520);
    check_frames("after burst reset");

    // Extreme values at arrival index 1 land on bin 256.
    for (int k = 0; k < NN; k++) begin
      if (k == 1) step(1'b1, 24'h7FFFFF, 24'h800000);
      else        step(1'b1, 24'($urandom), 24'($urandom));
    end
    idle(520);
    if (got_q.size() == NN) begin
      chk("extreme r", 64'(got_q[256].r), 64'h7FFFFF);
      chk("extreme i", 64'(got_q[256].i), 64'h800000);
    end
    check_frames("extreme");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
